// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC owner and single-outstanding instruction fetch sequencer
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_enable,
    input  logic [31:0] jump_target_address,
    input  logic        branEnable,
    input  logic [31:0] branAddress,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        fetch_error,
    output logic        misalign
);

    localparam int             TW   = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          r_state;
    logic [31:0]     r_pc;
    logic            r_drop;
    logic [TW-1:0]   r_timer;
    logic            r_instr_valid;
    logic [31:0]     r_instr_out;
    logic [31:0]     r_instr_pc;
    logic            r_fetch_error;
    logic            r_misalign;

    state_t          w_state_nx;
    logic [31:0]     w_pc_nx;
    logic            w_drop_nx;
    logic [TW-1:0]   w_timer_nx;
    logic            w_iv_nx;
    logic [31:0]     w_io_nx;
    logic [31:0]     w_ipc_nx;
    logic            w_ferr_nx;
    logic            w_mis_nx;

    // Jump outranks branch; redirects are ignored while idling out of reset
    logic [31:0]     w_target;
    logic [31:0]     w_target_al;
    logic            w_redirect;

    assign w_target    = jump_enable ? jump_target_address : branAddress;
    assign w_target_al = {w_target[31:2], 2'b00};
    assign w_redirect  = (jump_enable | branEnable) && (r_state != S_IDLE);

    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign fetch_error = r_fetch_error;
    assign misalign    = r_misalign;

    // Next-state, next-PC and output decode for the fetch FSM
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_drop_nx  = r_drop;
        w_timer_nx = r_timer;
        w_iv_nx    = r_instr_valid;
        w_io_nx    = r_instr_out;
        w_ipc_nx   = r_instr_pc;
        w_ferr_nx  = 1'b0;
        w_mis_nx   = w_redirect && (w_target[1:0] != 2'b00);
        imem_req   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nx = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (w_redirect) w_pc_nx = w_target_al;
                if (imem_ready) begin
                    // A request accepted on a redirect edge fetched the old PC, so its reply is stale
                    w_state_nx = S_WAIT;
                    w_timer_nx = '0;
                    w_drop_nx  = w_redirect;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_drop_nx = 1'b0;
                    if (r_drop || w_redirect) begin
                        w_state_nx = S_FETCH;
                        if (w_redirect) w_pc_nx = w_target_al;
                    end else begin
                        w_io_nx    = imem_rdata;
                        w_ipc_nx   = r_pc;
                        w_iv_nx    = 1'b1;
                        w_pc_nx    = r_pc + 32'd4;
                        w_state_nx = S_HOLD;
                    end
                end else if (r_timer == TMAX) begin
                    // Give up on this request and reissue; a redirect on this edge still moves the PC
                    w_ferr_nx  = 1'b1;
                    w_state_nx = S_FETCH;
                    w_drop_nx  = 1'b0;
                    w_timer_nx = '0;
                    if (w_redirect) w_pc_nx = w_target_al;
                end else begin
                    if (r_timer != '1) w_timer_nx = r_timer + 1'b1;
                    if (w_redirect) begin
                        w_drop_nx = 1'b1;
                        w_pc_nx   = w_target_al;
                    end
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    // Presented instruction is on the wrong path: flush even if decode is stalled
                    w_iv_nx    = 1'b0;
                    w_pc_nx    = w_target_al;
                    w_state_nx = S_FETCH;
                end else if (!stall) begin
                    w_iv_nx    = 1'b0;
                    w_state_nx = S_FETCH;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_VECTOR;
            r_drop        <= 1'b0;
            r_timer       <= '0;
            r_instr_valid <= 1'b0;
            r_instr_out   <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_fetch_error <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_pc          <= w_pc_nx;
            r_drop        <= w_drop_nx;
            r_timer       <= w_timer_nx;
            r_instr_valid <= w_iv_nx;
            r_instr_out   <= w_io_nx;
            r_instr_pc    <= w_ipc_nx;
            r_fetch_error <= w_ferr_nx;
            r_misalign    <= w_mis_nx;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        jump_enable;
    logic [31:0] jump_target_address;
    logic        branEnable;
    logic [31:0] branAddress;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fetch_error;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] sb[$];
    logic        prev_valid = 1'b0;

    fetch_controller #(.RESET_VECTOR(32'h0), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .jump_enable(jump_enable), .jump_target_address(jump_target_address),
        .branEnable(branEnable), .branAddress(branAddress),
        .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
        .fetch_error(fetch_error), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH at address pc; ends in HOLD with the word presented
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
        sb.push_back({pc, data});
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    // Monitor: every new presentation to decode is matched against the scoreboard
    always @(negedge clk) begin
        if (!reset && instr_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_instr_pc", instr_pc, 32'hxxxx_xxxx);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("mon_instr_pc", instr_pc, e[63:32]);
                check("mon_instr_out", instr_out, e[31:0]);
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        reset = 1'b1; jump_enable = 1'b0; jump_target_address = '0;
        branEnable = 1'b0; branAddress = '0; stall = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        // Reset state
        repeat (3) tick();
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_ferr", {31'd0, fetch_error}, 32'd0);
        check("rst_mis", {31'd0, misalign}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: first fetch from reset vector
        check("t1_req", {31'd0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'd0);
        fetch_one(32'h0, 32'h0050_0093);
        check("t1_valid", {31'd0, instr_valid}, 32'd1);
        check("t1_req_hold", {31'd0, imem_req}, 32'd0);
        tick();
        check("t1_valid_1cyc", {31'd0, instr_valid}, 32'd0);
        check("t1_next_addr", imem_addr, 32'd4);

        // 2: stall holds the presented instruction
        fetch_one(32'h4, 32'hAAAA_0001);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_valid", {31'd0, instr_valid}, 32'd1);
            check("t2_out", instr_out, 32'hAAAA_0001);
            check("t2_pc", instr_pc, 32'h4);
            check("t2_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("t2_req_after", {31'd0, imem_req}, 32'd1);
        check("t2_addr_after", imem_addr, 32'h8);

        // 3: jump during WAIT drops the in-flight response
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        jump_enable = 1'b1; jump_target_address = 32'h100;
        tick();
        jump_enable = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("t3_valid", {31'd0, instr_valid}, 32'd0);
        check("t3_req", {31'd0, imem_req}, 32'd1);
        check("t3_addr", imem_addr, 32'h100);

        // 4: jump beats branch in HOLD, flush despite stall
        fetch_one(32'h100, 32'h0000_0011);
        stall = 1'b1;
        jump_enable = 1'b1; jump_target_address = 32'h200;
        branEnable = 1'b1; branAddress = 32'h300;
        tick();
        jump_enable = 1'b0; branEnable = 1'b0; stall = 1'b0;
        check("t4_valid", {31'd0, instr_valid}, 32'd0);
        check("t4_addr", imem_addr, 32'h200);
        check("t4_mis", {31'd0, misalign}, 32'd0);

        // 5: timeout after 4 WAIT cycles, retry same address, late response ignored
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_ferr_early", {31'd0, fetch_error}, 32'd0);
            check("t5_req_wait", {31'd0, imem_req}, 32'd0);
        end
        tick();
        check("t5_ferr", {31'd0, fetch_error}, 32'd1);
        check("t5_req", {31'd0, imem_req}, 32'd1);
        check("t5_addr", imem_addr, 32'h200);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
        tick();
        imem_rvalid = 1'b0;
        check("t5_ferr_once", {31'd0, fetch_error}, 32'd0);
        check("t5_late_valid", {31'd0, instr_valid}, 32'd0);
        check("t5_late_addr", imem_addr, 32'h200);
        fetch_one(32'h200, 32'h0000_0022);
        tick();
        check("t5_next_addr", imem_addr, 32'h204);

        // 6: misaligned branch to top of memory, PC wraps
        branEnable = 1'b1; branAddress = 32'hFFFF_FFFE;
        tick();
        branEnable = 1'b0;
        check("t6_mis", {31'd0, misalign}, 32'd1);
        check("t6_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h0000_0033);
        check("t6_mis_clear", {31'd0, misalign}, 32'd0);
        tick();
        check("t6_wrap_addr", imem_addr, 32'h0);

        // Redirect on the accepting edge in FETCH: reply is stale
        imem_ready = 1'b1;
        jump_enable = 1'b1; jump_target_address = 32'h40;
        tick();
        imem_ready = 1'b0; jump_enable = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0044;
        tick();
        imem_rvalid = 1'b0;
        check("acc_redir_valid", {31'd0, instr_valid}, 32'd0);
        check("acc_redir_addr", imem_addr, 32'h40);

        // Reset mid-fetch: pending response afterwards is ignored
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        reset = 1'b1;
        #2;
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        tick();
        reset = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0055;
        tick();
        imem_rvalid = 1'b0;
        check("midrst_req_after", {31'd0, imem_req}, 32'd1);
        check("midrst_valid_after", {31'd0, instr_valid}, 32'd0);
        tick();
        check("midrst_valid_later", {31'd0, instr_valid}, 32'd0);

        repeat (2) tick();
        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
